uart_rx_sampler: RTL and testbench

Oversampling UART receiver that sits between the `rs232_rx` pin and the byte consumer inside `my_uart_top`. It synchronises the asynchronous line and samples it at 16× the baud rate, using a 3-sample majority vote at mid-bit. It recovers 8N1 frames LSB-first, rejects glitch start bits, and flags framing and overrun errors. Received bytes are handed downstream over a valid/ready handshake.

---
 rtl/uart_rx_sampler.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x oversampling UART receiver, 3-sample majority vote.
// Build option UART_RX_PARITY_EN adds an even-parity bit and parity_err.
module uart_rx_sampler #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int DW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_sampler: DIV must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic [DW-1:0]   r_div;
    logic [3:0]      r_samp;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_s7;
    logic            r_s8;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_busy;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_rxs;
    logic            w_tick;
    logic            w_s9;
    logic            w_wrap;
    logic            w_maj;
    logic            w_load;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_state != S_IDLE) && (r_div == DIV_M1);
    assign w_s9   = w_tick && (r_samp == 4'd9);
    assign w_wrap = w_tick && (r_samp == 4'd15);
    assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic r_parity_err;
    assign parity_err = r_parity_err;
    assign w_load = (r_state == S_STOP) && w_s9 && w_maj && !r_perr;

    // Parity check: flag the byte as bad and pulse at sample 9.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr       <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            if (r_state == S_START) begin
                r_perr <= 1'b0;
            end
            if (r_state == S_PARITY && w_s9) begin
                r_perr       <= (^r_shift) ^ w_maj;
                r_parity_err <= (^r_shift) ^ w_maj;
            end
        end
    end
`else
    assign w_load = (r_state == S_STOP) && w_s9 && w_maj;
`endif

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_busy   = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    // Two-flop synchroniser, idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rs232_rx;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; STOP decides at sample 9 so frames can abut.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_next = S_START;
            end
            S_START: begin
                if (w_s9 && w_maj) w_next = S_IDLE;
                else if (w_wrap)   w_next = S_DATA;
            end
            S_DATA: begin
`ifdef UART_RX_PARITY_EN
                if (w_wrap && r_bit == 3'd7) w_next = S_PARITY;
`else
                if (w_wrap && r_bit == 3'd7) w_next = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_wrap) w_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_s9) w_next = w_maj ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (w_rxs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Baud/sample counters, vote samples and data shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= '0;
            r_samp  <= 4'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_s7    <= 1'b1;
            r_s8    <= 1'b1;
        end else begin
            if (r_state == S_IDLE) begin
                r_div  <= '0;
                r_samp <= 4'd0;
            end else begin
                r_div <= w_tick ? '0 : r_div + DW'(1);
                if (w_tick) r_samp <= r_samp + 4'd1;
            end
            if (w_tick && r_samp == 4'd7) r_s7 <= w_rxs;
            if (w_tick && r_samp == 4'd8) r_s8 <= w_rxs;
            if (r_state == S_START) r_bit <= 3'd0;
            if (r_state == S_DATA && w_s9) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
            if (r_state == S_DATA && w_wrap) r_bit <= r_bit + 3'd1;
        end
    end

    // Output byte, handshake, error pulses and registered busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_busy      <= (w_next != S_IDLE);
            r_frame_err <= (r_state == S_STOP) && w_s9 && !w_maj;
            r_overrun   <= 1'b0;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_overrun  <= r_rx_valid && !rx_ready;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: frame-level model feeds a byte queue,
// a forked monitor pops and compares on every accepted byte.
`timescale 1ns/1ps
module tb_uart_rx_sampler;
    localparam int CLK_FREQ = 614_400;
    localparam int BAUD     = 9600;
    localparam int DIV      = CLK_FREQ / (BAUD * 16);
    localparam int BIT      = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int LAT      = 170 * DIV;
`else
    localparam int LAT      = 154 * DIV;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232_rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         n_vrise = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         n_perr = 0;
    int         t_vrise = 0;
    int         t_fall = 0;
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    logic [7:0] pend = 8'h00;
    logic       pend_v = 1'b0;
    logic [7:0] last_good = 8'h00;
    logic       prev_valid = 1'b0;

    uart_rx_sampler #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rs232_rx (rs232_rx),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (frame_err) n_ferr++;
                if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
                if (parity_err) n_perr++;
`endif
                if (rx_valid && !prev_valid) begin
                    n_vrise++;
                    t_vrise = cyc;
                end
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte got=%0h want=none",
                                 rx_data);
                    end else begin
                        chk("byte", int'(rx_data), int'(exp_q.pop_front()));
                    end
                end
                prev_valid = rx_valid;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b,
                              input int bl);
        rs232_rx = 1'b0;
        t_fall   = cyc;
        wait_clk(bl);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            wait_clk(bl);
        end
`ifdef UART_RX_PARITY_EN
        rs232_rx = (^b) ^ par_flip;
        wait_clk(bl);
`endif
        rs232_rx = stop_b;
        wait_clk(bl);
    endtask

    task automatic send_good(input logic [7:0] b, input int bl);
        int v0;
        int d;
        logic rdy;
        rdy = rx_ready;
        if (rdy) begin
            exp_q.push_back(b);
        end else begin
            if (pend_v) exp_ovr++;
            pend   = b;
            pend_v = 1'b1;
        end
        last_good = b;
        v0 = n_vrise;
        send_frame(b, 1'b1, bl);
        if (rdy) begin
            chk("valid_pulse", n_vrise - v0, 1);
            if (bl == BIT) begin
                d = t_vrise - t_fall;
                total++;
                if (d < LAT + 2 || d > LAT + 5) begin
                    bad++;
                    $display("FAIL valid_latency got=%0d want=%0d..%0d",
                             d, LAT + 2, LAT + 5);
                end
            end
        end
    endtask

    task automatic false_start(input int low_clks, input string name);
        logic seen;
        logic done;
        int   v0;
        seen = 1'b0;
        done = 1'b0;
        v0   = n_vrise;
        rs232_rx = 1'b0;
        for (int i = 0; i < 10 * DIV + 4; i++) begin
            wait_clk(1);
            if (i + 1 == low_clks) rs232_rx = 1'b1;
            if (rx_busy) begin
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
                break;
            end
        end
        rs232_rx = 1'b1;
        chk(name, int'(done), 1);
        wait_clk(BIT);
        chk("false_start_novalid", n_vrise - v0, 0);
        chk("false_start_idle", int'(rx_busy), 0);
    endtask

    initial begin
        int         v0;
        int         gap;
        int         bl;
        logic [7:0] b;
        logic [7:0] a9;
        fork
            monitor();
        join_none

        rst = 1'b1;
        wait_clk(6);
        rst = 1'b0;
        wait_clk(2);
        chk("rst_data", int'(rx_data), 8'h00);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_busy", int'(rx_busy), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_ovr", int'(overrun), 0);

        send_good(8'hA9, BIT);
        wait_clk(10 * BIT);
        send_good(8'hD4, BIT);
        chk("clean_ferr", n_ferr, 0);
        chk("clean_ovr", n_ovr, 0);
        wait_clk(BIT);

        false_start(2, "glitch_busy_clear");
        false_start(24, "short_low_busy_clear");

        v0 = n_vrise;
        exp_ferr++;
        send_frame(8'h55, 1'b0, BIT);
        wait_clk(20 * BIT);
        chk("break_busy", int'(rx_busy), 1);
        chk("ferr_count", n_ferr, exp_ferr);
        chk("ferr_data_kept", int'(rx_data), int'(last_good));
        chk("ferr_novalid", n_vrise - v0, 0);
        rs232_rx = 1'b1;
        wait_clk(4);
        chk("break_exit", int'(rx_busy), 0);
        wait_clk(BIT);

        rx_ready = 1'b0;
        send_good(8'h11, BIT);
        send_good(8'h22, BIT);
        wait_clk(4);
        chk("ovr_count", n_ovr, exp_ovr);
        chk("ovr_valid_held", int'(rx_valid), 1);
        chk("ovr_data", int'(rx_data), int'(pend));
        if (pend_v) begin
            exp_q.push_back(pend);
            pend_v = 1'b0;
        end
        rx_ready = 1'b1;
        wait_clk(1);
        chk("valid_clears", int'(rx_valid), 0);
        wait_clk(BIT);

        a9 = 8'hA9;
        v0 = n_vrise;
        rs232_rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = a9[i];
            wait_clk(BIT);
        end
        rs232_rx = a9[4];
        wait_clk(BIT / 2);
        rst = 1'b1;
        wait_clk(3);
        rs232_rx = 1'b1;
        rst = 1'b0;
        last_good = 8'h00;
        wait_clk(2);
        chk("midrst_data", int'(rx_data), int'(last_good));
        chk("midrst_busy", int'(rx_busy), 0);
        chk("midrst_valid", int'(rx_valid), 0);
        wait_clk(2 * BIT);
        chk("midrst_novalid", n_vrise - v0, 0);
        send_good(8'hD4, BIT);

        for (int n = 0; n < 8; n++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 2);
            bl  = (n == 6) ? BIT - 1 : (n == 7) ? BIT + 1 : BIT;
            send_good(b, bl);
            wait_clk(gap * BIT);
        end

`ifdef UART_RX_PARITY_EN
        wait_clk(BIT);
        v0 = n_vrise;
        par_flip = 1'b1;
        send_frame(8'hA9, 1'b1, BIT);
        par_flip = 1'b0;
        wait_clk(4);
        chk("perr_count", n_perr, 1);
        chk("perr_novalid", n_vrise - v0, 0);
        chk("perr_no_ovr", n_ovr, exp_ovr);
`endif

        wait_clk(BIT);
        chk("sb_drain", exp_q.size(), 0);
        chk("final_ferr", n_ferr, exp_ferr);
        chk("final_ovr", n_ovr, exp_ovr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
